// File: rtl/ct_byte_mover.sv
// Copies one ciphertext from the encrypter byte buffers into the decrypter byte buffers.
// Streams one byte per clock; RD_LAT sets the number of read-to-write pipeline stages.
module ct_byte_mover #(
    parameter int unsigned C_BYTES = 896,
    parameter int unsigned H_BYTES = 192,
    parameter int unsigned RD_LAT  = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_start,
    input  logic       i_abort,
    output logic       o_busy,
    output logic       o_done,
    output logic [7:0] o_src_addr_h,
    input  logic [7:0] i_src_dout_h,
    output logic [9:0] o_src_addr_c,
    input  logic [7:0] i_src_dout_c,
    output logic       o_dst_we_h,
    output logic [7:0] o_dst_addr_h,
    output logic [7:0] o_dst_di_h,
    output logic       o_dst_we_c,
    output logic [9:0] o_dst_addr_c,
    output logic [7:0] o_dst_di_c
);

    localparam logic [9:0] C_LAST = 10'(C_BYTES - 1);
    localparam logic [9:0] H_LIM  = 10'(H_BYTES);
    localparam logic [7:0] H_LAST = 8'(H_BYTES - 1);
    // Every valid stage except the one currently writing.
    localparam logic [RD_LAT-1:0] TAIL_MASK = {RD_LAT{1'b1}} >> 1;

    if (H_BYTES == 0 || H_BYTES > 256 || H_BYTES > C_BYTES || C_BYTES > 1024) begin : g_bad_size
        $error("ct_byte_mover: illegal C_BYTES/H_BYTES combination");
    end
    if (RD_LAT < 1 || RD_LAT > 3) begin : g_bad_lat
        $error("ct_byte_mover: RD_LAT must be 1..3");
    end

    typedef enum logic [1:0] {StIdle, StRun, StDrain, StFin} state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [9:0]        r_rd_cnt;
    logic [9:0]        r_wr_cnt;
    logic [RD_LAT-1:0] r_vld;
    logic [RD_LAT-1:0] r_hv;
    logic              w_issue;
    logic              w_rd_h;
    logic              w_drain_done;
    logic              w_we_c;
    logic              w_we_h;

    assign w_issue      = (r_state == StRun) && !i_abort;
    assign w_rd_h       = r_rd_cnt < H_LIM;
    assign w_drain_done = (r_vld & TAIL_MASK) == '0;
    assign w_we_c       = r_vld[RD_LAT-1];
    assign w_we_h       = r_hv[RD_LAT-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            StIdle: begin
                if (i_start && !i_abort) begin
                    w_state_nxt = StRun;
                end
            end
            StRun: begin
                if (i_abort) begin
                    w_state_nxt = StIdle;
                end else if (r_rd_cnt == C_LAST) begin
                    w_state_nxt = StDrain;
                end
            end
            StDrain: begin
                if (i_abort) begin
                    w_state_nxt = StIdle;
                end else if (w_drain_done) begin
                    w_state_nxt = StFin;
                end
            end
            StFin:   w_state_nxt = StIdle;
            default: w_state_nxt = StIdle;
        endcase
    end

    // Read address: counts through RUN and falls back to 0 otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_cnt <= '0;
        end else if (w_issue && (r_rd_cnt != C_LAST)) begin
            r_rd_cnt <= r_rd_cnt + 10'd1;
        end else begin
            r_rd_cnt <= '0;
        end
    end

    // Valid pipeline; the top stage is the registered write strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld <= '0;
            r_hv  <= '0;
        end else if (i_abort) begin
            r_vld <= '0;
            r_hv  <= '0;
        end else begin
            r_vld <= (r_vld << 1) | RD_LAT'(w_issue);
            r_hv  <= (r_hv << 1) | RD_LAT'(w_issue && w_rd_h);
        end
    end

    // Writes are gap-free, so the write address simply follows the strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_cnt <= '0;
        end else if (i_abort) begin
            r_wr_cnt <= '0;
        end else if (w_we_c) begin
            r_wr_cnt <= (r_wr_cnt == C_LAST) ? '0 : r_wr_cnt + 10'd1;
        end
    end

    always_comb begin
        o_busy       = (r_state == StRun) || (r_state == StDrain);
        o_done       = (r_state == StFin);
        o_src_addr_c = r_rd_cnt;
        o_src_addr_h = w_rd_h ? r_rd_cnt[7:0] : H_LAST;
        o_dst_we_c   = w_we_c;
        o_dst_we_h   = w_we_h;
        o_dst_addr_c = r_wr_cnt;
        o_dst_addr_h = r_wr_cnt[7:0];
        o_dst_di_c   = w_we_c ? i_src_dout_c : 8'h00;
        o_dst_di_h   = w_we_h ? i_src_dout_h : 8'h00;
    end

endmodule

// File: tb/tb_ct_byte_mover.sv
// Bench for ct_byte_mover: two instances (RD_LAT 1 and 3) share stimulus and are checked
// every cycle against a timeline model derived from the start cycle of each transfer.
module tb_ct_byte_mover;

    localparam int C   = 896;
    localparam int H   = 192;
    localparam int INF = 32'h7fffffff;

    logic clk = 1'b0;
    logic rst_n;
    logic start;
    logic abort;

    logic       busy_w [2];
    logic       done_w [2];
    logic       we_h   [2];
    logic       we_c   [2];
    logic [7:0] sa_h   [2];
    logic [7:0] sd_h   [2];
    logic [7:0] da_h   [2];
    logic [7:0] di_h   [2];
    logic [9:0] sa_c   [2];
    logic [7:0] sd_c   [2];
    logic [9:0] da_c   [2];
    logic [7:0] di_c   [2];

    logic [9:0] pipe_c [2][3];
    logic [7:0] pipe_h [2][3];

    int t0  [2];
    int cut [2];
    int wc  [2];
    int wh  [2];
    int dc  [2];
    int cyc;
    int checks;
    int errors;

    ct_byte_mover #(.C_BYTES(C), .H_BYTES(H), .RD_LAT(1)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .i_start(start), .i_abort(abort),
        .o_busy(busy_w[0]), .o_done(done_w[0]),
        .o_src_addr_h(sa_h[0]), .i_src_dout_h(sd_h[0]),
        .o_src_addr_c(sa_c[0]), .i_src_dout_c(sd_c[0]),
        .o_dst_we_h(we_h[0]), .o_dst_addr_h(da_h[0]), .o_dst_di_h(di_h[0]),
        .o_dst_we_c(we_c[0]), .o_dst_addr_c(da_c[0]), .o_dst_di_c(di_c[0])
    );

    ct_byte_mover #(.C_BYTES(C), .H_BYTES(H), .RD_LAT(3)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .i_start(start), .i_abort(abort),
        .o_busy(busy_w[1]), .o_done(done_w[1]),
        .o_src_addr_h(sa_h[1]), .i_src_dout_h(sd_h[1]),
        .o_src_addr_c(sa_c[1]), .i_src_dout_c(sd_c[1]),
        .o_dst_we_h(we_h[1]), .o_dst_addr_h(da_h[1]), .o_dst_di_h(di_h[1]),
        .o_dst_we_c(we_c[1]), .o_dst_addr_c(da_c[1]), .o_dst_di_c(di_c[1])
    );

    initial forever #5 clk = ~clk;

    function automatic logic [7:0] fc(input logic [9:0] a);
        return a[7:0] + {6'b0, a[9:8]};
    endfunction

    function automatic logic [7:0] fh(input logic [7:0] a);
        return a ^ 8'hA5;
    endfunction

    function automatic int lat(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    function automatic int done_rel(input int i);
        return (i == 0) ? 898 : 900;
    endfunction

    // Encrypter buffers: data appears RD_LAT clocks after the address.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            pipe_c[i][0] <= sa_c[i];
            pipe_h[i][0] <= sa_h[i];
            for (int j = 1; j < 3; j++) begin
                pipe_c[i][j] <= pipe_c[i][j-1];
                pipe_h[i][j] <= pipe_h[i][j-1];
            end
        end
    end

    assign sd_c[0] = fc(pipe_c[0][0]);
    assign sd_h[0] = fh(pipe_h[0][0]);
    assign sd_c[1] = fc(pipe_c[1][2]);
    assign sd_h[1] = fh(pipe_h[1][2]);

    // 0 idle, 1 busy, 2 done cycle
    function automatic int phase(input int i);
        int rel;
        if (t0[i] < 0 || cyc >= cut[i]) return 0;
        rel = cyc - t0[i];
        if (rel >= 1 && rel <= C + lat(i)) return 1;
        if (rel == C + lat(i) + 1) return 2;
        return 0;
    endfunction

    task automatic chk(input string nm, input int i, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s dut%0d cyc %0d: got %0d expected %0d", nm, i, cyc, act, exp);
        end
    endtask

    task automatic compare();
        for (int i = 0; i < 2; i++) begin
            int p;
            int rel;
            int k;
            bit ewc;
            bit ewh;
            p   = phase(i);
            rel = cyc - t0[i];
            k   = rel - 1 - lat(i);
            ewc = (p == 1) && (rel >= 1 + lat(i));
            ewh = ewc && (k < H);
            chk("busy", i, int'(busy_w[i]), int'(p == 1));
            chk("done", i, int'(done_w[i]), int'(p == 2));
            chk("we_c", i, int'(we_c[i]), int'(ewc));
            chk("we_h", i, int'(we_h[i]), int'(ewh));
            if (ewc) begin
                chk("addr_c", i, int'(da_c[i]), k);
                chk("data_c", i, int'(di_c[i]), int'(fc(10'(k))));
            end else begin
                chk("data_c idle", i, int'(di_c[i]), 0);
            end
            if (ewh) begin
                chk("addr_h", i, int'(da_h[i]), k);
                chk("data_h", i, int'(di_h[i]), int'(fh(8'(k))));
            end else begin
                chk("data_h idle", i, int'(di_h[i]), 0);
            end
            if (p == 1 && rel <= C) begin
                chk("src_addr_c", i, int'(sa_c[i]), rel - 1);
                chk("src_addr_h", i, int'(sa_h[i]), (rel - 1 < H) ? rel - 1 : H - 1);
            end
            if (!rst_n) begin
                chk("reset src_addr_c", i, int'(sa_c[i]), 0);
                chk("reset src_addr_h", i, int'(sa_h[i]), 0);
                chk("reset dst_addr_c", i, int'(da_c[i]), 0);
                chk("reset dst_addr_h", i, int'(da_h[i]), 0);
            end
            // Hand-computed bytes pin the source formulas.
            if (we_c[i] && da_c[i] == 10'h1FF) chk("c byte 1FF", i, int'(di_c[i]), 8'h00);
            if (we_c[i] && da_c[i] == 10'h305) chk("c byte 305", i, int'(di_c[i]), 8'h08);
            if (we_h[i] && da_h[i] == 8'hBF)   chk("h byte BF", i, int'(di_h[i]), 8'h1A);
            if (p == 1 && rel == 1) begin
                wc[i] = 0;
                wh[i] = 0;
            end
            if (we_c[i]) wc[i]++;
            if (we_h[i]) wh[i]++;
            if (done_w[i]) begin
                dc[i]++;
                chk("done latency", i, rel, done_rel(i));
                chk("c-write total", i, wc[i], 896);
                chk("h-write total", i, wh[i], 192);
            end
        end
    endtask

    // One clock: compare at the falling edge, then advance the model on the rising edge.
    task automatic tick();
        @(negedge clk);
        compare();
        @(posedge clk);
        if (rst_n) begin
            for (int i = 0; i < 2; i++) begin
                int p;
                p = phase(i);
                if (p == 0 && start && !abort) begin
                    t0[i]  = cyc;
                    cut[i] = INF;
                end else if (p == 1 && abort) begin
                    cut[i] = cyc + 1;
                end
            end
        end
        cyc++;
        #1;
    endtask

    task automatic run_to(input int c);
        while (cyc < c) tick();
    endtask

    task automatic pulse_start(output int s);
        s     = cyc;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        int s;
        rst_n  = 1'b0;
        start  = 1'b0;
        abort  = 1'b0;
        cyc    = 0;
        checks = 0;
        errors = 0;
        for (int i = 0; i < 2; i++) begin
            t0[i]  = -1;
            cut[i] = INF;
            wc[i]  = 0;
            wh[i]  = 0;
            dc[i]  = 0;
        end
        @(posedge clk);
        #1;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        // Plain transfer
        pulse_start(s);
        run_to(s + 905);
        chk("done count t1", 0, dc[0], 1);
        chk("done count t1", 1, dc[1], 1);

        // Start while busy is ignored
        pulse_start(s);
        run_to(s + 100);
        start = 1'b1;
        tick();
        start = 1'b0;
        run_to(s + 905);
        chk("done count t2", 0, dc[0], 2);
        chk("done count t2", 1, dc[1], 2);

        // Abort mid-transfer, then a clean transfer
        pulse_start(s);
        run_to(s + 300);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        run_to(s + 305);
        chk("busy after abort", 0, int'(busy_w[0]), 0);
        chk("busy after abort", 1, int'(busy_w[1]), 0);
        chk("c-writes before abort", 0, wc[0], 299);
        chk("c-writes before abort", 1, wc[1], 297);
        chk("done count abort", 0, dc[0], 2);
        chk("done count abort", 1, dc[1], 2);
        pulse_start(s);
        run_to(s + 905);
        chk("done count t3", 0, dc[0], 3);
        chk("done count t3", 1, dc[1], 3);

        // Asynchronous reset mid-clock during a transfer
        pulse_start(s);
        run_to(s + 500);
        #2;
        rst_n = 1'b0;
        t0[0] = -1;
        t0[1] = -1;
        tick();
        tick();
        #2;
        rst_n = 1'b1;
        run_to(s + 510);
        chk("c-writes before reset", 0, wc[0], 498);
        chk("c-writes before reset", 1, wc[1], 496);
        chk("done count reset", 0, dc[0], 3);
        pulse_start(s);
        run_to(s + 905);
        chk("done count t4", 0, dc[0], 4);
        chk("done count t4", 1, dc[1], 4);

        // start and abort together in IDLE: abort wins
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        tick();
        chk("busy start+abort", 0, int'(busy_w[0]), 0);
        chk("busy start+abort", 1, int'(busy_w[1]), 0);

        // start held high: back-to-back transfers with one idle cycle
        s     = cyc;
        start = 1'b1;
        run_to(s + 902);
        start = 1'b0;
        run_to(s + 1806);
        chk("done count held", 0, dc[0], 6);
        chk("done count held", 1, dc[1], 6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
